// File: rtl/mmio_io_bridge.sv
// Memory-mapped I/O bridge: LED registers, debounced switches and a sticky change flag
// in the top quarter of the data address space. Optional change interrupt via MMIO_IRQ_EN.
module mmio_io_bridge #(
  parameter int WIDTH           = 16,
  parameter int ADDR_BITS       = 10,
  parameter int NUM_OUT         = 4,
  parameter int LED_BITS        = 10,
  parameter int SW_BITS         = 10,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDR_BITS-1:0]         addr_a,
  input  logic [WIDTH-1:0]             wdata_a,
  input  logic                         we_a,
  input  logic [WIDTH-1:0]             mem_q_a,
  output logic [WIDTH-1:0]             rdata_a,
  input  logic [ADDR_BITS-1:0]         addr_b,
  input  logic [WIDTH-1:0]             wdata_b,
  input  logic                         we_b,
  input  logic [WIDTH-1:0]             mem_q_b,
  output logic [WIDTH-1:0]             rdata_b,
  output logic                         mem_we_a,
  output logic                         mem_we_b,
  input  logic [SW_BITS-1:0]           switches,
  output logic [NUM_OUT*LED_BITS-1:0]  leds,
  output logic                         irq
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] SW_OFF = 4'(NUM_OUT);
  localparam logic [3:0] ST_OFF = 4'(NUM_OUT + 1);

  typedef enum logic {IDLE, COUNT} state_t;

  logic       io_a, io_b, wr_a, wr_b;
  logic [3:0] off_a, off_b;

  assign io_a     = (addr_a[ADDR_BITS-1 -: 2] == 2'b11);
  assign io_b     = (addr_b[ADDR_BITS-1 -: 2] == 2'b11);
  assign off_a    = addr_a[3:0];
  assign off_b    = addr_b[3:0];
  assign wr_a     = we_a & io_a;
  assign wr_b     = we_b & io_b;
  assign mem_we_a = we_a & ~io_a;
  assign mem_we_b = we_b & ~io_b;

  // Only the region select and offset bits of the address are decoded.
  logic unused_bits;
  assign unused_bits = ^{addr_a, addr_b, wdata_a, wdata_b};

  // LED registers; port A takes priority when both ports hit the same one.
  logic [LED_BITS-1:0]         led_reg [NUM_OUT];
  logic [NUM_OUT*LED_BITS-1:0] led_flat;

  generate
    for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_led
      always_ff @(posedge clk) begin
        if (reset) begin
          led_reg[gi] <= '0;
        end else if (wr_a && off_a == 4'(gi)) begin
          led_reg[gi] <= wdata_a[LED_BITS-1:0];
        end else if (wr_b && off_b == 4'(gi)) begin
          led_reg[gi] <= wdata_b[LED_BITS-1:0];
        end
      end
      assign led_flat[gi*LED_BITS +: LED_BITS] = led_reg[gi];
    end
  endgenerate

  assign leds = led_flat;

  // Switch synchroniser and debounce FSM.
  logic [SW_BITS-1:0] sync1_reg, sync2_reg, stable_reg;
  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               accept;
  logic               differs;

  assign differs = (sync2_reg != stable_reg);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg  <= '0;
      sync2_reg  <= '0;
      stable_reg <= '0;
      state_reg  <= IDLE;
      cnt_reg    <= '0;
    end else begin
      sync1_reg <= switches;
      sync2_reg <= sync1_reg;
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        stable_reg <= sync2_reg;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (differs) state_next = COUNT;
      COUNT:   if (!differs || cnt_reg == CNT_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cnt_next = '0;
    accept   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (differs) cnt_next = CNT_W'(1);
      end
      COUNT: begin
        if (differs && cnt_reg == CNT_LAST) begin
          accept = 1'b1;
        end else if (differs) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: cnt_next = '0;
    endcase
  end

  // Status register: a new accepted change outranks a same-cycle clear.
  logic       st_wr_a, st_wr_b, st_clr;
  logic       flag_reg;
  logic [1:0] status_val;

  assign st_wr_a = wr_a && (off_a == ST_OFF);
  assign st_wr_b = wr_b && (off_b == ST_OFF);
  assign st_clr  = st_wr_a ? wdata_a[0] : (st_wr_b & wdata_b[0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      flag_reg <= 1'b0;
    end else if (accept) begin
      flag_reg <= 1'b1;
    end else if (st_clr) begin
      flag_reg <= 1'b0;
    end
  end

`ifdef MMIO_IRQ_EN
  logic mask_reg, irq_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_reg <= 1'b0;
      irq_reg  <= 1'b0;
    end else begin
      if (st_wr_a) begin
        mask_reg <= wdata_a[1];
      end else if (st_wr_b) begin
        mask_reg <= wdata_b[1];
      end
      irq_reg <= flag_reg & mask_reg;
    end
  end

  assign status_val = {mask_reg, flag_reg};
  assign irq        = irq_reg;
`else
  assign status_val = {1'b0, flag_reg};
  assign irq        = 1'b0;
`endif

  function automatic logic [WIDTH-1:0] io_read(
    input logic [3:0]                  off,
    input logic [NUM_OUT*LED_BITS-1:0] ledv,
    input logic [SW_BITS-1:0]          sw,
    input logic [1:0]                  st
  );
    io_read = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (off == 4'(k)) io_read[LED_BITS-1:0] = ledv[k*LED_BITS +: LED_BITS];
    end
    if (off == SW_OFF) io_read[SW_BITS-1:0] = sw;
    if (off == ST_OFF) io_read[1:0] = st;
  endfunction

  // Registered I/O read path lines up with the BRAM's one-cycle read latency.
  logic             sel_q_a, sel_q_b;
  logic [WIDTH-1:0] iodata_q_a, iodata_q_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q_a    <= 1'b0;
      sel_q_b    <= 1'b0;
      iodata_q_a <= '0;
      iodata_q_b <= '0;
    end else begin
      sel_q_a    <= io_a;
      sel_q_b    <= io_b;
      iodata_q_a <= io_read(off_a, led_flat, stable_reg, status_val);
      iodata_q_b <= io_read(off_b, led_flat, stable_reg, status_val);
    end
  end

  assign rdata_a = sel_q_a ? iodata_q_a : mem_q_a;
  assign rdata_b = sel_q_b ? iodata_q_b : mem_q_b;

endmodule

// File: tb/tb_mmio_io_bridge.sv
// Scoreboard bench for mmio_io_bridge: reads push expected data, a negedge monitor
// pops and compares one cycle later; static outputs are checked directly.
module tb_mmio_io_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  addr_a, addr_b;
  logic [15:0] wdata_a, wdata_b, mem_q_a, mem_q_b, rdata_a, rdata_b;
  logic        we_a, we_b, mem_we_a, mem_we_b, irq;
  logic [9:0]  switches;
  logic [39:0] leds;

  mmio_io_bridge #(
    .WIDTH(16), .ADDR_BITS(10), .NUM_OUT(4), .LED_BITS(10), .SW_BITS(10), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset),
    .addr_a(addr_a), .wdata_a(wdata_a), .we_a(we_a), .mem_q_a(mem_q_a), .rdata_a(rdata_a),
    .addr_b(addr_b), .wdata_b(wdata_b), .we_b(we_b), .mem_q_b(mem_q_b), .rdata_b(rdata_b),
    .mem_we_a(mem_we_a), .mem_we_b(mem_we_b),
    .switches(switches), .leds(leds), .irq(irq)
  );

  always #5 clk = ~clk;

`ifdef MMIO_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_a[$], exp_b[$];
  string       nm_a[$], nm_b[$];
  logic        rd_a = 1'b0, rd_b = 1'b0, rd_a_d = 1'b0, rd_b_d = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  always @(posedge clk) begin
    rd_a_d <= rd_a;
    rd_b_d <= rd_b;
  end

  // Monitor: read data is presented the cycle after the address.
  always @(negedge clk) begin
    if (rd_a_d) begin
      if (exp_a.size() == 0) begin
        errors++;
        $display("FAIL rd_a: unexpected read data 0x%0h", rdata_a);
      end else begin
        chk(nm_a.pop_front(), rdata_a, exp_a.pop_front());
      end
    end
    if (rd_b_d) begin
      if (exp_b.size() == 0) begin
        errors++;
        $display("FAIL rd_b: unexpected read data 0x%0h", rdata_b);
      end else begin
        chk(nm_b.pop_front(), rdata_b, exp_b.pop_front());
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rda(input logic [9:0] a, input logic [15:0] e, input string n);
    addr_a = a; we_a = 1'b0; rd_a = 1'b1;
    exp_a.push_back(e); nm_a.push_back(n);
    tick();
    rd_a = 1'b0;
  endtask

  task automatic rdb(input logic [9:0] a, input logic [15:0] e, input string n);
    addr_b = a; we_b = 1'b0; rd_b = 1'b1;
    exp_b.push_back(e); nm_b.push_back(n);
    tick();
    rd_b = 1'b0;
  endtask

  task automatic wra(input logic [9:0] a, input logic [15:0] d);
    addr_a = a; wdata_a = d; we_a = 1'b1;
    tick();
    we_a = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0; we_a = 1'b0; we_b = 1'b0;
    mem_q_a = 16'h1234; mem_q_b = 16'h5678; switches = '0;
    repeat (2) tick();
    chk("reset_leds", leds[15:0] | leds[39:24] | 16'(leds[23:16]), 16'h0);
    chk("reset_irq", 16'(irq), 16'h0);
    chk("reset_rdata_a", rdata_a, 16'h1234);
    chk("reset_rdata_b", rdata_b, 16'h5678);
    reset = 1'b0;
    tick();
    rda(10'h305, 16'h0000, "reset_status");

    // Both ports write different LED registers in the same cycle.
    addr_a = 10'h300; wdata_a = 16'h03FF; we_a = 1'b1;
    addr_b = 10'h301; wdata_b = 16'h0155; we_b = 1'b1;
    #1;
    chk("mem_we_a_io", 16'(mem_we_a), 16'h0);
    chk("mem_we_b_io", 16'(mem_we_b), 16'h0);
    tick();
    we_a = 1'b0; we_b = 1'b0;
    chk("led0", 16'(leds[9:0]), 16'h03FF);
    chk("led1", 16'(leds[19:10]), 16'h0155);
    addr_a = 10'h010; we_a = 1'b1; addr_b = 10'h2FF; we_b = 1'b1;
    #1;
    chk("mem_we_a_mem", 16'(mem_we_a), 16'h1);
    chk("mem_we_b_mem", 16'(mem_we_b), 16'h1);
    we_a = 1'b0; we_b = 1'b0;

    // Read mux: BRAM region vs I/O region.
    mem_q_a = 16'hBEEF;
    rda(10'h010, 16'hBEEF, "rd_mem_a");
    rda(10'h300, 16'h03FF, "rd_led0");
    rdb(10'h301, 16'h0155, "rd_led1_b");
    rda(10'h30F, 16'h0000, "rd_unmapped");
    rda(10'h304, 16'h0000, "rd_switch_init");

    // Debounce: accepted at the 6th edge after the switch change.
    switches = 10'h2A5;
    repeat (5) tick();
    rda(10'h304, 16'h0000, "deb_before_accept");
    rda(10'h304, 16'h02A5, "deb_accepted");
    rda(10'h305, 16'h0001, "deb_flag");

    // Glitch shorter than the debounce window is rejected.
    switches = 10'h000;
    repeat (2) tick();
    switches = 10'h2A5;
    repeat (10) tick();
    rda(10'h304, 16'h02A5, "glitch_stable");
    rda(10'h305, 16'h0001, "glitch_flag");

    // Write-1-to-clear, then clear colliding with a fresh accept.
    wra(10'h305, 16'h0001);
    rda(10'h305, 16'h0000, "flag_cleared");
    switches = 10'h155;
    repeat (5) tick();
    wra(10'h305, 16'h0001);
    rda(10'h305, 16'h0001, "clear_vs_set");
    rda(10'h304, 16'h0155, "second_accept");

    // Same-register conflict: port A wins.
    addr_a = 10'h302; wdata_a = 16'h0011; we_a = 1'b1;
    addr_b = 10'h302; wdata_b = 16'h0022; we_b = 1'b1;
    tick();
    we_a = 1'b0; we_b = 1'b0;
    rda(10'h302, 16'h0011, "conflict_a_wins");
    chk("led2", 16'(leds[29:20]), 16'h0011);

    // A read in the same cycle as a write returns the old value.
    addr_a = 10'h303; wdata_a = 16'h00AA; we_a = 1'b1;
    addr_b = 10'h303; rd_b = 1'b1;
    exp_b.push_back(16'h0000); nm_b.push_back("rd_during_write");
    tick();
    we_a = 1'b0; rd_b = 1'b0;
    rdb(10'h303, 16'h00AA, "rd_after_write");

    // Mask write; irq follows flag & mask one cycle later when implemented.
    wra(10'h305, 16'h0002);
    chk("irq_not_yet", 16'(irq), 16'h0);
    rda(10'h305, {14'h0, IRQ_ON, 1'b1}, "status_mask");
    chk("irq_asserted", 16'(irq), 16'(IRQ_ON));

    // Reset in the middle of a debounce count.
    switches = 10'h0F0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_leds_lo", leds[15:0], 16'h0);
    chk("rst2_leds_hi", leds[39:24], 16'h0);
    chk("rst2_irq", 16'(irq), 16'h0);
    rda(10'h305, 16'h0000, "rst2_status");
    repeat (4) tick();
    rda(10'h304, 16'h0000, "rst2_before_accept");
    rda(10'h304, 16'h00F0, "rst2_accepted");
    rda(10'h305, 16'h0001, "rst2_flag");
    rda(10'h020, 16'hBEEF, "rst2_rd_mem");

    repeat (2) tick();
    chk("queue_a_drained", 16'(exp_a.size()), 16'h0);
    chk("queue_b_drained", 16'(exp_b.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_io_bridge.md
Name: mmio_io_bridge

Overview:
- Parametrised memory-mapped I/O bridge between the dual-port data memory and the 16-bit datapath.
- Decodes the top I/O region on both memory ports and provides:
  - NUM_OUT writable LED registers;
  - a synchronised, debounced switch register;
  - a sticky change-status register.
- Muxes I/O read data against BRAM read data with matched 1-cycle latency.

Parameters:
- WIDTH, 16, datapath/memory word width
- ADDR_BITS, 10, memory address width
- NUM_OUT, 4, number of LED output registers (1..8)
- LED_BITS, 10, width of each LED register (<= WIDTH)
- SW_BITS, 10, switch input width (<= WIDTH)
- DEBOUNCE_CYCLES, 50000, stable cycles required before a switch change is accepted (>= 2)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- addr_a  in  ADDR_BITS  port A address
- wdata_a  in  WIDTH  port A write data
- we_a  in  1  port A write enable
- mem_q_a  in  WIDTH  port A BRAM read data (1-cycle latency)
- rdata_a  out  WIDTH  port A read data to datapath
- addr_b, wdata_b, we_b, mem_q_b, rdata_b  as port A, for port B
- mem_we_a  out  1  we_a gated off in I/O region
- mem_we_b  out  1  we_b gated off in I/O region
- switches  in  SW_BITS  asynchronous board switches
- leds  out  NUM_OUT*LED_BITS  LED registers, register k at bits [k*LED_BITS +: LED_BITS]
- irq  out  1  change interrupt (see Optional Feature)

Behaviour:
- Clock and reset: one clock `clk`. Reset is synchronous, active-high, named `reset`.
- I/O decode: io_x = (addr_x[ADDR_BITS-1:ADDR_BITS-2] == 2'b11). Offset = addr_x[3:0].
- mem_we_x = we_x & ~io_x (combinational). The BRAM is never written in the I/O region.
- Register map (offset: access):
  - 0..NUM_OUT-1: LED reg, R/W; write stores wdata[LED_BITS-1:0]; reads zero-extended.
  - NUM_OUT: switch stable value, RO; writes ignored.
  - NUM_OUT+1: status, R/W. Bit0 = change flag, write-1-to-clear. Bit1 = irq mask (R/W only with MMIO_IRQ_EN, else reads 0). Other bits read 0.
  - Other offsets: read 0, writes ignored.
- Writes: take effect at the rising edge where we_x & io_x.
  - Both ports write the same register in one cycle: port A wins.
- Reads, 1-cycle latency:
  - Each cycle, register io_x into sel_q_x and the addressed I/O value into iodata_q_x.
  - rdata_x = sel_q_x ? iodata_q_x : mem_q_x.
  - Read data for an address appears the cycle after presentation, aligned with BRAM data.
  - A read of a register written in the same cycle returns the old value.
- Switch path:
  - 2-flop synchroniser, sync2 = second stage.
  - Debounce FSM, states IDLE and COUNT, counter width clog2(DEBOUNCE_CYCLES).
  - IDLE: if sync2 != stable, go to COUNT with cnt = 1.
  - COUNT: if sync2 == stable, go to IDLE with cnt = 0. Otherwise cnt++.
  - COUNT: when cnt == DEBOUNCE_CYCLES-1 and sync2 still differs: stable <= sync2, flag <= 1, go to IDLE.
  - If sync2 changes to another value that still differs from stable, cnt continues and the final sampled sync2 is captured.
- Flag set and write-1-clear in the same cycle: set wins, flag stays 1.
- Reset values:
  - All LED regs 0; leds = 0.
  - Synchroniser 0, stable 0, cnt 0, FSM IDLE.
  - flag 0, mask 0.
  - sel_q 0, iodata_q 0; rdata_x follows mem_q_x.
  - irq 0.
- Reset mid-debounce aborts the count. Non-zero switches after reset re-debounce from stable = 0 and set flag.

Optional Feature:
- Macro MMIO_IRQ_EN.
- Defined: status bit1 is the R/W mask, and irq = flag & mask, registered (asserts 1 cycle after both are 1).
- Undefined: mask not implemented (reads 0), irq tied 0.
- Register map otherwise identical.

Test Plan:
- LED write: DEBOUNCE_CYCLES=4. Port A writes 0x03FF to 0x300, port B writes 0x0155 to 0x301 the same cycle -> next cycle leds[9:0]=0x3FF, leds[19:10]=0x155. mem_we_a and mem_we_b both 0 during the writes.
- Read mux: mem_q_a=0xBEEF, read addr 0x010 -> rdata_a=0xBEEF the next cycle. Read 0x300 after the LED write -> rdata_a=0x03FF the next cycle.
- Debounce: switches 0x000->0x2A5 held -> after 2 sync + 4 debounce cycles, read 0x304 returns 0x02A5 and status bit0=1.
- Glitch rejection: 0x2A5->0x000 for 2 cycles, then back to 0x2A5 -> stable stays 0x2A5, flag unchanged.
- Status clear: write 0x0001 to 0x305 -> bit0 reads 0. Clear coinciding with a new accepted change -> bit0 stays 1.
- Same-register conflict and reset:
  - Both ports write 0x302 (A=0x011, B=0x022) -> reads 0x011.
  - With MMIO_IRQ_EN: mask=1 and flag=1 -> irq=1. Assert reset for 1 cycle mid-debounce -> leds=0, irq=0, flag=0, and the count restarts.
